// File: rtl/rgb_float_sequencer.sv
// rgb_float_sequencer: takes one RGB pixel per handshake and runs its three
// channels, one per cycle, through a single external combinational
// uint8 -> float32 converter. The three floats are then presented together on
// a valid/ready output. A wrapping counter tracks completed output handshakes.
module rgb_float_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       pix_r,
  input  logic [7:0]       pix_g,
  input  logic [7:0]       pix_b,
  output logic [7:0]       conv_int,
  input  logic [31:0]      conv_float,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r_f,
  output logic [31:0]      out_g_f,
  output logic [31:0]      out_b_f,
  output logic [CNT_W-1:0] pix_count,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_R = 3'd1,
    CONV_G = 3'd2,
    CONV_B = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         r_q, g_q, b_q;
  logic [31:0]        out_r_q, out_g_q, out_b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               out_hs;

  // Next state, input ready and converter operand. conv_int is a pure
  // function of the state and channel registers, so it is stable all cycle.
  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    conv_int  = 8'd0;
    case (state_q)
      IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid) state_d = CONV_R;
      end
      CONV_R: begin
        conv_int = r_q;
        state_d  = CONV_G;
      end
      CONV_G: begin
        conv_int = g_q;
        state_d  = CONV_B;
      end
      CONV_B: begin
        conv_int = b_q;
        state_d  = HOLD;
      end
      HOLD: begin
        // A new pixel may be taken in the same cycle the result is consumed.
        pix_ready = out_ready;
        if (out_ready) state_d = pix_valid ? CONV_R : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = pix_valid && pix_ready;
  assign out_valid = (state_q == HOLD);
  assign out_hs    = out_valid && out_ready;
  assign busy      = (state_q != IDLE);
  assign out_r_f   = out_r_q;
  assign out_g_f   = out_g_q;
  assign out_b_f   = out_b_q;
  assign pix_count = cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Channel registers capture the pixel only on an accepted input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 8'd0;
      g_q <= 8'd0;
      b_q <= 8'd0;
    end else if (accept) begin
      r_q <= pix_r;
      g_q <= pix_g;
      b_q <= pix_b;
    end
  end

  // Converter result captured into the channel slot selected by the state;
  // the slots otherwise keep their value until the next pixel overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r_q <= 32'd0;
      out_g_q <= 32'd0;
      out_b_q <= 32'd0;
    end else begin
      if (state_q == CONV_R) out_r_q <= conv_float;
      if (state_q == CONV_G) out_g_q <= conv_float;
      if (state_q == CONV_B) out_b_q <= conv_float;
    end
  end

  // Completed-pixel counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (out_hs) cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_rgb_float_sequencer.sv
// Testbench for rgb_float_sequencer: table of pixels with hand-computed float
// encodings plus directed sequences for back-pressure, streaming, ignored
// input during conversion, mid-pixel reset and counter wrap (CNT_W=4 copy).
module tb_rgb_float_sequencer;

  typedef struct {
    logic [7:0]  r, g, b;
    logic [31:0] fr, fg, fb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        out_ready;

  logic        pix_ready, out_valid, busy;
  logic [7:0]  conv_int;
  logic [31:0] conv_float, out_r_f, out_g_f, out_b_f;
  logic [15:0] pix_count;

  logic        pix_ready4, out_valid4, busy4;
  logic [7:0]  conv_int4;
  logic [31:0] conv_float4, out_r_f4, out_g_f4, out_b_f4;
  logic [3:0]  pix_count4;

  int          n_pass = 0;
  int          n_total = 0;
  int          exp_cnt = 0;
  vec_t        tbl [6];

  always #5 clk = ~clk;

  // Behavioural model of the external uint8 -> float32 converter.
  function automatic logic [31:0] u8_to_f32(input logic [7:0] v);
    int e;
    logic [31:0] m;
    if (v == 8'd0) return 32'd0;
    e = 7;
    while (v[e] == 1'b0) e--;
    m = (32'(v) << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  assign conv_float  = u8_to_f32(conv_int);
  assign conv_float4 = u8_to_f32(conv_int4);

  rgb_float_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .conv_int(conv_int), .conv_float(conv_float),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r_f(out_r_f), .out_g_f(out_g_f), .out_b_f(out_b_f),
    .pix_count(pix_count), .busy(busy)
  );

  rgb_float_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready4),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .conv_int(conv_int4), .conv_float(conv_float4),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_r_f(out_r_f4), .out_g_f(out_g_f4), .out_b_f(out_b_f4),
    .pix_count(pix_count4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_count();
    chk("pix_count", 32'(pix_count), 32'(exp_cnt[15:0]));
    chk("pix_count4", 32'(pix_count4), 32'(exp_cnt[3:0]));
  endtask

  // One complete pixel from IDLE with out_ready=1, checking every stage.
  task automatic run_pixel(input vec_t v);
    int n;
    pix_r = v.r; pix_g = v.g; pix_b = v.b;
    pix_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!pix_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_accept", 32'(pix_ready), 32'd1);
    tick();
    pix_valid = 1'b0;
    chk("conv_r", 32'(conv_int), 32'(v.r));
    chk("ready_in_conv", 32'(pix_ready), 32'd0);
    chk("valid_in_conv", 32'(out_valid), 32'd0);
    tick();
    chk("conv_g", 32'(conv_int), 32'(v.g));
    tick();
    chk("conv_b", 32'(conv_int), 32'(v.b));
    tick();
    chk("valid_hold", 32'(out_valid), 32'd1);
    chk("conv_hold_zero", 32'(conv_int), 32'd0);
    chk("out_r_f", out_r_f, v.fr);
    chk("out_g_f", out_g_f, v.fg);
    chk("out_b_f", out_b_f, v.fb);
    chk_count();
    tick();
    exp_cnt++;
    chk("busy_after", 32'(busy), 32'd0);
    chk("valid_after", 32'(out_valid), 32'd0);
    chk_count();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{r: 8'd0,   g: 8'd1,   b: 8'd255, fr: 32'h0000_0000, fg: 32'h3F80_0000, fb: 32'h437F_0000};
    tbl[1] = '{r: 8'd128, g: 8'd200, b: 8'd3,   fr: 32'h4300_0000, fg: 32'h4348_0000, fb: 32'h4040_0000};
    tbl[2] = '{r: 8'd2,   g: 8'd10,  b: 8'd100, fr: 32'h4000_0000, fg: 32'h4120_0000, fb: 32'h42C8_0000};
    tbl[3] = '{r: 8'd64,  g: 8'd7,   b: 8'd15,  fr: 32'h4280_0000, fg: 32'h40E0_0000, fb: 32'h4170_0000};
    tbl[4] = '{r: 8'd16,  g: 8'd50,  b: 8'd127, fr: 32'h4180_0000, fg: 32'h4248_0000, fb: 32'h42FE_0000};
    tbl[5] = '{r: 8'd255, g: 8'd0,   b: 8'd1,   fr: 32'h437F_0000, fg: 32'h0000_0000, fb: 32'h3F80_0000};

    rst_n = 1'b0; pix_valid = 1'b0; out_ready = 1'b0;
    pix_r = 8'd0; pix_g = 8'd0; pix_b = 8'd0;
    #13;
    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conv", 32'(conv_int), 32'd0);
    chk("rst_out_r", out_r_f, 32'd0);
    chk_count();
    rst_n = 1'b1;
    tick();

    // Table-driven single pixels
    for (int i = 0; i < 6; i++) run_pixel(tbl[i]);

    // Back-pressure: HOLD for 10 cycles with out_ready=0
    pix_r = 8'd128; pix_g = 8'd200; pix_b = 8'd3;
    pix_valid = 1'b1; out_ready = 1'b0;
    tick();
    pix_valid = 1'b0;
    tick(); tick(); tick();
    pix_r = 8'd9; pix_g = 8'd9; pix_b = 8'd9;
    pix_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_ready", 32'(pix_ready), 32'd0);
      chk("bp_r", out_r_f, 32'h4300_0000);
      chk("bp_g", out_g_f, 32'h4348_0000);
      chk("bp_b", out_b_f, 32'h4040_0000);
      chk("bp_count", 32'(pix_count), 32'(exp_cnt[15:0]));
      tick();
    end
    pix_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_ready_follows", 32'(pix_ready), 32'd1);
    tick();
    exp_cnt++;
    chk_count();
    chk("bp_idle", 32'(busy), 32'd0);

    // Continuous stream of 8 pixels, back-to-back
    pix_r = tbl[0].r; pix_g = tbl[0].g; pix_b = tbl[0].b;
    pix_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("st_conv_r", 32'(conv_int), 32'(tbl[k % 6].r));
      chk("st_busy", 32'(busy), 32'd1);
      pix_r = tbl[(k + 1) % 6].r; pix_g = tbl[(k + 1) % 6].g; pix_b = tbl[(k + 1) % 6].b;
      tick();
      chk("st_conv_g", 32'(conv_int), 32'(tbl[k % 6].g));
      tick();
      chk("st_conv_b", 32'(conv_int), 32'(tbl[k % 6].b));
      tick();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_out_r", out_r_f, tbl[k % 6].fr);
      chk("st_out_b", out_b_f, tbl[k % 6].fb);
      chk("st_ready", 32'(pix_ready), 32'd1);
      exp_cnt++;
      if (k == 7) pix_valid = 1'b0;
    end
    tick();
    chk("st_idle", 32'(busy), 32'd0);
    chk_count();

    // pix_valid toggling with changing data during conversion
    pix_r = 8'd2; pix_g = 8'd10; pix_b = 8'd100;
    pix_valid = 1'b1;
    tick();
    pix_r = 8'd77;
    chk("tg_ready", 32'(pix_ready), 32'd0);
    chk("tg_conv_r", 32'(conv_int), 32'd2);
    tick();
    pix_valid = 1'b0; pix_g = 8'd33;
    chk("tg_conv_g", 32'(conv_int), 32'd10);
    tick();
    pix_valid = 1'b1; pix_r = 8'd99;
    chk("tg_conv_b", 32'(conv_int), 32'd100);
    tick();
    pix_valid = 1'b0;
    chk("tg_out_r", out_r_f, 32'h4000_0000);
    chk("tg_out_g", out_g_f, 32'h4120_0000);
    chk("tg_out_b", out_b_f, 32'h42C8_0000);
    tick();
    exp_cnt++;
    chk("tg_idle", 32'(busy), 32'd0);
    chk_count();

    // Asynchronous reset during CONV_G
    pix_r = 8'd200; pix_g = 8'd64; pix_b = 8'd7;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    chk("mr_in_conv_g", 32'(conv_int), 32'd64);
    chk("mr_r_loaded", out_r_f, 32'h4348_0000);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_conv", 32'(conv_int), 32'd0);
    chk("mr_out_r", out_r_f, 32'd0);
    chk("mr_ready", 32'(pix_ready), 32'd1);
    chk_count();
    #1 rst_n = 1'b1;
    run_pixel(tbl[4]);

    // Counter wrap on the CNT_W=4 instance: 17 pixels from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();
    for (int p = 0; p < 17; p++) run_pixel(tbl[p % 6]);
    chk("wrap_final4", 32'(pix_count4), 32'd1);
    chk("wrap_final16", 32'(pix_count), 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
